// File: rtl/uartrx_if.sv
// Consumer-side handshake of the UART receiver: the go request/acknowledge
// and the byte presented with its data-ready and framing flags.
interface uartrx_if;
  logic       go;
  logic [7:0] data;
  logic       dr;
  logic       frame_err;

  modport master (output go, input data, dr, frame_err);
  modport slave  (input go, output data, dr, frame_err);
endinterface

// File: rtl/uartrx.sv
// 8N1 UART receiver, LSB first. Mid-bit sampling is timed from the falling
// edge of the synchronized line; the byte is held until go is lowered.
module uartrx_cfg_chk #(
  parameter int unsigned BitTime = 32'd4
) ();
  if (BitTime < 32'd4) begin : g_bit_time_too_small
    $error("uartrx: BIT_TIME must be at least 4");
  end
endmodule

module uartrx #(
  parameter int unsigned ClockFrequencyHz = 32'd66_000_000,
  parameter int unsigned BaudRate         = 32'd9600
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  uartrx_if.slave  bus
);
  localparam int unsigned BIT_TIME = ClockFrequencyHz / BaudRate;
  localparam int unsigned HALF     = BIT_TIME / 32'd2;
  localparam int unsigned CW       = (BIT_TIME > 32'd1) ? $clog2(BIT_TIME) : 32'd1;

  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 32'd1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_TIME - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] START_BIT   = 3'd1;
  localparam logic [2:0] DATA_BITS   = 3'd2;
  localparam logic [2:0] STOP_BIT    = 3'd3;
  localparam logic [2:0] WAIT_GO_LOW = 3'd4;

  uartrx_cfg_chk #(.BitTime(BIT_TIME)) u_cfg_chk ();

  logic          rx_meta_r;
  logic          rx_s_r;
  logic          rx_prev_r;
  logic          fall_s;
  logic [2:0]    state_r;
  logic [CW-1:0] counter_r;
  logic [2:0]    bit_count_r;
  logic [7:0]    shift_r;
  logic [7:0]    data_r;
  logic          dr_r;
  logic          frame_err_r;

  // Two-flop synchronizer plus previous-sample register; idle-high reset values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
    end
  end

  assign fall_s = rx_prev_r & ~rx_s_r;

  // Receive FSM: each timed state acts in the cycle its down-counter reaches zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      counter_r   <= CNT_ZERO;
      bit_count_r <= 3'd0;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      dr_r        <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.go && fall_s) begin
            counter_r <= HALF_LOAD;
            state_r   <= START_BIT;
          end
        end
        START_BIT: begin
          if (counter_r != CNT_ZERO) begin
            counter_r <= counter_r - CNT_ONE;
          end else if (!rx_s_r) begin
            counter_r   <= BIT_LOAD;
            bit_count_r <= 3'd0;
            state_r     <= DATA_BITS;
          end else begin
            // Line was high again at mid start bit: treat as a glitch.
            state_r <= IDLE;
          end
        end
        DATA_BITS: begin
          if (counter_r != CNT_ZERO) begin
            counter_r <= counter_r - CNT_ONE;
          end else begin
            shift_r     <= {rx_s_r, shift_r[7:1]};
            bit_count_r <= bit_count_r + 3'd1;
            counter_r   <= BIT_LOAD;
            if (bit_count_r == 3'd7) begin
              state_r <= STOP_BIT;
            end
          end
        end
        STOP_BIT: begin
          if (counter_r != CNT_ZERO) begin
            counter_r <= counter_r - CNT_ONE;
          end else begin
            data_r      <= shift_r;
            frame_err_r <= ~rx_s_r;
            dr_r        <= 1'b1;
            state_r     <= WAIT_GO_LOW;
          end
        end
        WAIT_GO_LOW: begin
          if (!bus.go) begin
            dr_r        <= 1'b0;
            frame_err_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          dr_r        <= 1'b0;
          frame_err_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.data      = data_r;
  assign bus.dr        = dr_r;
  assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_uartrx.sv
// Randomized scoreboard bench for uartrx at 10 clocks per bit: frames are
// queued with their expected byte, flags, arrival cycle and dr pulse width.
module tb_uartrx;
  typedef struct {
    logic [7:0] data;
    logic       fe;
    int         rise;
    int         width;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic go_stim;
  logic ack_low;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ack_delay = 0;
  exp_t exp_q[$];

  uartrx_if u_if ();
  assign u_if.go = go_stim & ~ack_low;

  uartrx #(.ClockFrequencyHz(20), .BaudRate(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, 10 cycles each.
  // Pin-to-dr latency is 2 + HALF + 9*BIT_TIME + 1 = 98 cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit exp,
                            input int drop_bit, input int rst_bit);
    logic [9:0] bits;
    int         c0;
    int         w;
    bits = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    c0 = cyc;
    w  = (drop_bit >= 0) ? 1 : ack_delay + 1;
    if (exp) exp_q.push_back('{b, ~stop, c0 + 98, w});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (drop_bit >= 0 && i == drop_bit + 1) go_stim = 1'b0;
      for (int j = 0; j < 10; j++) begin
        if (rst_bit >= 0 && i == rst_bit + 1 && j == 5) begin
          rst_n   = 1'b0;
          go_stim = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          chk("mid_reset_dr", int'(u_if.dr), 0);
          chk("mid_reset_frame_err", int'(u_if.frame_err), 0);
          chk("mid_reset_data", int'(u_if.data), 0);
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on each dr rise and measures the pulse width.
  initial begin
    logic dr_prev;
    int   width_cnt;
    int   exp_width;
    exp_t e;
    dr_prev   = 1'b0;
    width_cnt = 0;
    exp_width = 0;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.dr && !dr_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", int'(u_if.data), -1);
          exp_width = 0;
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", int'(u_if.data), int'(e.data));
          chk("byte_frame_err", int'(u_if.frame_err), int'(e.fe));
          chk("byte_arrival_cycle", cyc, e.rise);
          exp_width = e.width;
        end
        width_cnt = 1;
      end else if (u_if.dr && dr_prev) begin
        width_cnt++;
      end else if (!u_if.dr && dr_prev) begin
        if (exp_width != 0) chk("dr_pulse_width", width_cnt, exp_width);
      end
      dr_prev = u_if.dr;
    end
  end

  // Consumer: acknowledges a presented byte by lowering go for one cycle.
  initial begin
    ack_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.dr) begin
        repeat (ack_delay) @(negedge clk);
        ack_low = 1'b1;
        @(negedge clk);
        chk("dr_fall_after_ack", int'(u_if.dr), 0);
        ack_low = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    rst_n   = 1'b0;
    rx      = 1'b1;
    go_stim = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dr", int'(u_if.dr), 0);
    chk("reset_frame_err", int'(u_if.frame_err), 0);
    chk("reset_data", int'(u_if.data), 0);
    rst_n = 1'b1;
    idle(5);

    // 1: single byte, dr held for several cycles before acknowledge
    ack_delay = 7;
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    idle(20);

    // 2: back-to-back bytes, acknowledged during the stop bit
    ack_delay = 0;
    send_frame(8'h00, 1'b1, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1, -1);
    idle(15);

    // 3: framing error, then a held-low line must not start a byte
    ack_delay = 2;
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    repeat (30) @(posedge clk);
    #1;
    idle(20);
    send_frame(8'h11, 1'b1, 1'b1, -1, -1);
    idle(15);

    // 4: short low glitch is rejected at the start-bit sample
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    send_frame(8'h5A, 1'b1, 1'b1, -1, -1);
    idle(15);

    // 5: ignored while go is low, then go dropped mid-byte
    ack_delay = 0;
    go_stim = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, -1, -1);
    idle(15);
    go_stim = 1'b1;
    idle(5);
    send_frame(8'h42, 1'b1, 1'b1, 4, -1);
    idle(10);
    go_stim = 1'b1;
    idle(5);

    // 6: reset during data bit 3 discards the partial byte
    ack_delay = 1;
    send_frame(8'hC3, 1'b1, 1'b0, -1, 3);
    idle(10);
    go_stim = 1'b1;
    idle(5);
    send_frame(8'h81, 1'b1, 1'b1, -1, -1);
    idle(15);

    // Random bytes, stop bits, acknowledge delays and idle gaps
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom_range(255, 0));
      rs = ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0;
      ack_delay = int'($urandom_range(4, 0));
      send_frame(rb, rs, 1'b1, -1, -1);
      idle(ack_delay + int'($urandom_range(8, 2)));
    end

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    idle(20);
    chk("all_bytes_received", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uartrx.md
Name: uartrx

Overview:
UART receiver, 8N1, LSB first. It is the counterpart of the team's UART transmitter and shares its go/busy-style handshake.
- Samples the asynchronous rx line through a 2-FF synchronizer.
- Deserializes one byte and presents it with a data-ready flag.
- Holds the byte until the consumer acknowledges by dropping go.
- Sits beside the transmitter in the SoC UART peripheral.

Parameters:
- ClockFrequencyHz, 66_000_000, system clock frequency.
- BaudRate, 9600, line bit rate.
- Derived BIT_TIME = ClockFrequencyHz / BaudRate (integer divide), HALF = BIT_TIME / 2.
- Elaboration assertion: BIT_TIME >= 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- rx  input  1  UART line, asynchronous, idle high
- go  input  1  high = consumer wants a byte; lowering it acknowledges a presented byte
- data  output  8  received byte; valid while dr=1
- dr  output  1  data ready; byte complete
- frame_err  output  1  qualifies the presented byte (valid while dr=1): stop bit sampled low

Behaviour:
Reset:
- state=Idle, dr=0, frame_err=0, data=0.
- Both synchronizer flops and the previous-sample register reset to 1.

Synchronizer:
- rx_s is rx after 2 flops.
- rx_prev is rx_s delayed 1 cycle.
- A falling edge is rx_prev=1 and rx_s=0.

Counter convention:
- bit_time_counter has width $clog2(BIT_TIME).
- It is loaded on state entry and decrements each cycle.
- The state's action fires in the cycle where the counter equals 0.

States:
- Idle:
  - If go=1 and a falling edge is seen (cycle D), load counter=HALF-1 and go to StartBit.
  - Edges while go=0 are ignored.
- StartBit:
  - At counter 0 (cycle D+HALF), sample rx_s.
  - If rx_s=0: counter=BIT_TIME-1, bit_count=0, go to DataBits.
  - If rx_s=1 (glitch/false start): go to Idle with no output change.
- DataBits:
  - At counter 0, shift rx_s into a shift register at the MSB (shift right), so bit0 lands at the LSB after 8 shifts.
  - Then bit_count+1 and reload BIT_TIME-1.
  - After bit_count=7 is sampled, go to StopBit.
  - Bit k is sampled at D+HALF+(k+1)*BIT_TIME.
- StopBit:
  - At counter 0 (D+HALF+9*BIT_TIME), copy the shift register to data.
  - frame_err <= ~rx_s, dr <= 1, go to WaitForGoLow.
  - dr and data become visible in cycle D+HALF+9*BIT_TIME+1.
- WaitForGoLow:
  - data, dr and frame_err are held.
  - Line activity is ignored; bytes arriving here are lost.
  - When go=0: dr <= 0, frame_err <= 0, go to Idle. data keeps its last value.

Boundary conditions:
- go dropped mid-byte (StartBit/DataBits/StopBit): reception completes; dr asserts; the FSM leaves WaitForGoLow on the next cycle because go=0, so dr pulses for exactly 1 cycle.
- Break, or rx held low after a framing error: no new start until rx_s returns high and falls again, because an edge is required.
- go high with rx already low on entry to Idle: no start, because there is no edge.
- Reset asserted in any state: next cycle returns to reset values; a partial byte is discarded.
- Odd BIT_TIME: HALF rounds down, so the sample point is 0.5 cycle early; this is accepted.
- Latency from the rx pin falling edge to dr: 2 (synchronizer) + HALF + 9*BIT_TIME + 1 cycles.

Test Plan:
Common bench setup: ClockFrequencyHz=20, BaudRate=2, so BIT_TIME=10, HALF=5. The line is driven at exactly 10 cycles per bit.

1. go=1; send 0xA5 with stop=1 -> dr rises exactly 96 cycles after the rx_s falling-edge cycle; data=0xA5, frame_err=0; dr stays 1 until go=0, then falls the next cycle.
2. Back-to-back 0x00 then 0xFF, dropping go for 1 cycle and re-raising it between the bytes during the stop bit -> both received correctly, frame_err=0 each time.
3. Send 0x3C with the stop bit driven 0 -> dr=1, data=0x3C, frame_err=1; rx then held low for 30 cycles and released -> no spurious byte; the next 0x11 is received with frame_err=0.
4. 3-cycle low glitch on rx with go=1 -> start sample is 1, FSM returns to Idle, dr never asserts; a following 0x5A is received correctly.
5. go=0 while a full 0x77 frame is sent -> dr stays 0. Then go=1, drop go at bit 4 of 0x42 -> dr=1 for exactly 1 cycle with data=0x42.
6. rst_n=0 for 1 cycle during data bit 3 of 0xC3 -> dr=0, frame_err=0, data=0x00 next cycle; a subsequent 0x81 is received correctly.
